int_ctrl: RTL and testbench
===========================

# int_ctrl

Interrupt controller that sequences the single-cycle CPU's program counter around external events. It latches rising edges on up to `N_IRQ` request lines, applies a software-written mask and fixed priority, and forces the datapath PC to a per-line vector. It saves the return address and hands it back on a return-from-interrupt instruction. It sits beside the control unit: the control unit decodes mask writes and `reti`, and the datapath's PC mux takes `take_int`/`int_vec` and `pc_ret`.

## Interface

Parameters:
- `N_IRQ`, 4: number of request lines; index 0 has the highest priority.
- `PC_W`, 10: program-counter width.
- `VEC_BASE`, 10'h3C0: vector of line 0. Line i vectors to `VEC_BASE + 4*i`, truncated mod 2^PC_W.
- `NEST_DEPTH`, 4: return-stack depth. Only used with `INT_NEST_EN`; otherwise the depth is 1.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `irq` in N_IRQ: external requests, synchronous to `clk`.
- `mask_we` in 1: write-enable for the mask, from the control unit.
- `mask_in` in N_IRQ: new mask value; 1 = enabled.
- `reti` in 1: return-from-interrupt decoded this cycle.
- `pc_next` in PC_W: next PC as computed by the datapath this cycle.
- `take_int` out 1: one-cycle pulse; the datapath loads `int_vec` into PC at the end of this cycle.
- `int_vec` out PC_W: vector of the interrupt being dispatched.
- `pc_ret` out PC_W: return address at top of stack; the datapath loads it when `reti`=1.
- `in_service` out 1: a handler is active.
- `cur_id` out $clog2(N_IRQ): id of the active handler.
- `pending` out N_IRQ: latched, not-yet-dispatched requests.

## Operation

Reset values:
- `mask`=0, `pending`=0, `irq_q`=0.
- State IDLE, stack empty.
- `take_int`=0, `int_vec`=0, `pc_ret`=0, `in_service`=0, `cur_id`=0.

Edge capture:
- `pending[i]` is set on the clock edge where `irq[i] & ~irq_q[i]`.
- Level-held lines do not re-trigger.
- If set and clear hit the same bit in the same cycle, set wins.

Mask:
- Written at the edge where `mask_we`=1.
- Arbitration in that cycle uses the old mask.

Candidate:
- The lowest index of `pending & mask`, registered values only.

State machine:
- **IDLE**: if a candidate exists, go to DISPATCH. At that edge, latch `id` into `cur_id`, clear `pending[id]` and register `int_vec`.
- **DISPATCH**: `take_int`=1 for exactly this cycle. At the edge, push `pc_next` and the previous `cur_id` onto the stack, then go to SERVICE. The instruction executing in this cycle completes; only its PC update is overridden.
- **SERVICE**: `in_service`=1. On `reti`=1, pop at the edge. If the stack is then empty, go to IDLE; otherwise stay in SERVICE with the popped `cur_id`.

`pc_ret` is combinational from the top of the stack, so it is valid throughout SERVICE.

Ignored events:
- `reti` in IDLE or DISPATCH: no effect.
- Masked pending bits: stay pending, and dispatch once unmasked.

## Timing

- Latency from an `irq` edge to `take_int` is 2 cycles: the `pending` edge, then the IDLE→DISPATCH edge, with `take_int` high in the following cycle.
- After a `reti` to IDLE, at least one IDLE cycle elapses before the next DISPATCH. This guarantees one instruction of the interrupted code executes.
- `reset` mid-DISPATCH or mid-SERVICE aborts the handler; all state returns to reset values at that edge.

## Configuration

`INT_NEST_EN`:
- **Defined**:
  - In SERVICE, a candidate with index strictly lower than `cur_id` preempts the handler and goes to DISPATCH, provided the stack depth is below `NEST_DEPTH`.
  - When the stack is full, preemption is deferred until a pop.
  - `reti` and a preemption candidate in the same cycle: the pop takes priority, and preemption is re-evaluated next cycle.
- **Undefined**: no dispatch from SERVICE, and the stack reduces to one register.

## Structure

- Shared package `int_pkg`:
  - state enum (IDLE, DISPATCH, SERVICE)
  - default `N_IRQ`, `PC_W`, `VEC_BASE` constants
  - vector stride constant (4)
- Sub-module `ret_stack`:
  - parameterised LIFO of `{PC_W, id}` entries with push, pop, empty and full flags.
  - A simultaneous push and pop is illegal and is never issued by the FSM.

## Test plan

All scenarios use the defaults.

1. **Basic dispatch and return.** Mask=4'b1111, `irq[2]` rises at cycle 0, `pc_next`=10'h015 during DISPATCH. Required: `take_int` high in cycle 2 with `int_vec`=10'h3C8; `cur_id`=2; `pc_ret`=10'h015. On `reti` the controller goes to IDLE and `in_service`=0.
2. **Priority.** `irq[3]` and `irq[1]` rise in the same cycle. Required: line 1 dispatches first (vector 10'h3C4); `pending`=4'b1000 remains. Line 3 dispatches after `reti` plus one IDLE cycle.
3. **Masking.** Mask=4'b1110, `irq[0]` rises. Required: `pending[0]`=1 and no `take_int`. Writing mask=4'b1111 produces dispatch to 10'h3C0 two cycles after the write edge.
4. **Level hold.** `irq[1]` held high for 20 cycles. Required: exactly one dispatch.
5. **Nesting, `INT_NEST_EN` only.** While serving line 3, `irq[0]` rises. Required: preempt to 10'h3C0. The first `reti` restores `cur_id`=3 and returns to the saved PC; the second `reti` returns to IDLE. Without the macro, line 0 waits until after the first `reti`.
6. **Reset mid-operation.** Assert `reset` in SERVICE with `pending`=4'b0100. Required: all outputs at reset values on the next cycle, and no dispatch afterwards.

Source files
------------

// File: rtl/int_pkg.sv
// ============================================================================
// Module  : int_pkg
// Brief   : Shared types and default constants for the interrupt controller.
// Revision: 1.0
// ============================================================================
`default_nettype none

package int_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_DISPATCH = 2'd1,
        ST_SERVICE  = 2'd2
    } state_t;

    localparam int         C_N_IRQ      = 4;
    localparam int         C_PC_W       = 10;
    localparam logic [9:0] C_VEC_BASE   = 10'h3C0;
    localparam int         C_NEST_DEPTH = 4;
    localparam int         C_VEC_STRIDE = 4;

endpackage

`default_nettype wire

// File: rtl/int_ctrl_ret_stack.sv
// ============================================================================
// Module  : ret_stack
// Brief   : LIFO of {return PC, previous id} entries; top is read combinationally.
// Revision: 1.0
// ============================================================================
`default_nettype none

module ret_stack #(
    parameter int DEPTH = 1,
    parameter int W     = 12
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_din,
    output logic [W-1:0] o_top,
    output logic         o_empty,
    output logic         o_full,
    output logic         o_one
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [W-1:0]     r_mem [DEPTH];
    logic [CNT_W-1:0] r_cnt;

    assign o_empty = (r_cnt == '0);
    assign o_full  = (r_cnt == CNT_W'(DEPTH));
    assign o_one   = (r_cnt == CNT_W'(1));

    // An empty stack reads as zero so the return address idles at its reset value.
    always_comb begin
        o_top = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CNT_W'(i + 1) == r_cnt) begin
                o_top = r_mem[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push && !o_full) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CNT_W'(i) == r_cnt) begin
                    r_mem[i] <= i_din;
                end
            end
            r_cnt <= r_cnt + CNT_W'(1);
        end else if (i_pop && !o_empty) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

endmodule

`default_nettype wire

// File: rtl/int_ctrl.sv
// ============================================================================
// Module  : int_ctrl
// Brief   : Edge-latched, masked, fixed-priority interrupt sequencer for the
//           CPU program counter. Define INT_NEST_EN to allow preemption.
// Revision: 1.0
// ============================================================================
`default_nettype none

module int_ctrl
    import int_pkg::*;
#(
    parameter int              N_IRQ      = C_N_IRQ,
    parameter int              PC_W       = C_PC_W,
    parameter logic [PC_W-1:0] VEC_BASE   = PC_W'(C_VEC_BASE),
    parameter int              NEST_DEPTH = C_NEST_DEPTH,
    localparam int             ID_W       = (N_IRQ > 1) ? $clog2(N_IRQ) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [N_IRQ-1:0]  irq,
    input  logic              mask_we,
    input  logic [N_IRQ-1:0]  mask_in,
    input  logic              reti,
    input  logic [PC_W-1:0]   pc_next,
    output logic              take_int,
    output logic [PC_W-1:0]   int_vec,
    output logic [PC_W-1:0]   pc_ret,
    output logic              in_service,
    output logic [ID_W-1:0]   cur_id,
    output logic [N_IRQ-1:0]  pending
);

`ifdef INT_NEST_EN
    localparam int C_DEPTH = NEST_DEPTH;
`else
    localparam int C_DEPTH = 1;
`endif

    state_t             r_state;
    logic [N_IRQ-1:0]   r_irq_q;
    logic [N_IRQ-1:0]   r_mask;
    logic [N_IRQ-1:0]   r_pending;
    logic [ID_W-1:0]    r_cur_id;
    logic [ID_W-1:0]    r_prev_id;
    logic [PC_W-1:0]    r_int_vec;
    logic               r_take_int;
    logic               r_in_service;

    logic [N_IRQ-1:0]   w_req;
    logic [N_IRQ-1:0]   w_rise;
    logic [N_IRQ-1:0]   w_clr;
    logic               w_cand_valid;
    logic [ID_W-1:0]    w_cand_id;
    logic [PC_W-1:0]    w_vec;
    logic               w_preempt;
    logic               w_dispatch;
    logic               w_push;
    logic               w_pop;
    logic [PC_W+ID_W-1:0] w_top;
    logic               w_empty;
    logic               w_full;
    logic               w_one;

    assign w_rise = irq & ~r_irq_q;
    assign w_req  = r_pending & r_mask;

    always_comb begin
        w_cand_valid = |w_req;
        w_cand_id    = '0;
        for (int i = N_IRQ - 1; i >= 0; i--) begin
            if (w_req[i]) begin
                w_cand_id = ID_W'(i);
            end
        end
    end

    assign w_vec = VEC_BASE + PC_W'(C_VEC_STRIDE) * PC_W'(w_cand_id);

`ifdef INT_NEST_EN
    // A return in the same cycle wins; preemption is reconsidered afterwards.
    assign w_preempt = (r_state == ST_SERVICE) && !reti && w_cand_valid
                       && (w_cand_id < r_cur_id) && !w_full;
`else
    assign w_preempt = 1'b0;
`endif

    assign w_dispatch = ((r_state == ST_IDLE) && w_cand_valid) || w_preempt;
    assign w_push     = (r_state == ST_DISPATCH) && !w_full;
    assign w_pop      = (r_state == ST_SERVICE) && reti && !w_empty;

    always_comb begin
        w_clr = '0;
        if (w_dispatch) begin
            w_clr[w_cand_id] = 1'b1;
        end
    end

    ret_stack #(
        .DEPTH (C_DEPTH),
        .W     (PC_W + ID_W)
    ) u_ret_stack (
        .clk     (clk),
        .rst     (reset),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_din   ({pc_next, r_prev_id}),
        .o_top   (w_top),
        .o_empty (w_empty),
        .o_full  (w_full),
        .o_one   (w_one)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_irq_q      <= '0;
            r_mask       <= '0;
            r_pending    <= '0;
            r_cur_id     <= '0;
            r_prev_id    <= '0;
            r_int_vec    <= '0;
            r_take_int   <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            r_irq_q    <= irq;
            r_pending  <= (r_pending & ~w_clr) | w_rise;
            r_take_int <= 1'b0;
            if (mask_we) begin
                r_mask <= mask_in;
            end
            if (w_dispatch) begin
                r_state      <= ST_DISPATCH;
                r_take_int   <= 1'b1;
                r_cur_id     <= w_cand_id;
                r_prev_id    <= r_cur_id;
                r_int_vec    <= w_vec;
                r_in_service <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                    end
                    ST_DISPATCH: begin
                        r_state      <= ST_SERVICE;
                        r_in_service <= 1'b1;
                    end
                    ST_SERVICE: begin
                        // The popped entry carries the id of the handler being resumed.
                        if (w_pop) begin
                            r_cur_id <= w_top[ID_W-1:0];
                            if (w_one) begin
                                r_state      <= ST_IDLE;
                                r_in_service <= 1'b0;
                            end
                        end
                    end
                    default: begin
                        r_state      <= ST_IDLE;
                        r_in_service <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign take_int   = r_take_int;
    assign int_vec    = r_int_vec;
    assign pc_ret     = w_top[PC_W+ID_W-1:ID_W];
    assign in_service = r_in_service;
    assign cur_id     = r_cur_id;
    assign pending    = r_pending;

endmodule

`default_nettype wire

// File: tb/tb_int_ctrl.sv
// ============================================================================
// Module  : tb_int_ctrl
// Brief   : Self-checking bench for int_ctrl; expected vectors are queued
//           when requests are raised and consumed on each take_int.
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_int_ctrl;

    localparam int N_IRQ = 4;
    localparam int PC_W  = 10;
    localparam int ID_W  = 2;

    logic             clk = 1'b0;
    logic             reset;
    logic [N_IRQ-1:0] irq;
    logic             mask_we;
    logic [N_IRQ-1:0] mask_in;
    logic             reti;
    logic [PC_W-1:0]  pc_next;
    logic             take_int;
    logic [PC_W-1:0]  int_vec;
    logic [PC_W-1:0]  pc_ret;
    logic             in_service;
    logic [ID_W-1:0]  cur_id;
    logic [N_IRQ-1:0] pending;

    int total  = 0;
    int bad    = 0;
    int n_disp = 0;
    int n0;
    logic [PC_W-1:0] exp_q [$];
    logic [PC_W-1:0] exp_v;

    int_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .irq        (irq),
        .mask_we    (mask_we),
        .mask_in    (mask_in),
        .reti       (reti),
        .pc_next    (pc_next),
        .take_int   (take_int),
        .int_vec    (int_vec),
        .pc_ret     (pc_ret),
        .in_service (in_service),
        .cur_id     (cur_id),
        .pending    (pending)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (take_int === 1'b1) n_disp++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1; irq = '0; mask_we = 1'b0; mask_in = '0; reti = 1'b0; pc_next = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic set_mask(input logic [N_IRQ-1:0] m);
        mask_we = 1'b1; mask_in = m;
        step();
        mask_we = 1'b0;
    endtask

    task automatic do_reti;
        reti = 1'b1;
        step();
        reti = 1'b0;
    endtask

    task automatic pop_exp;
        if (exp_q.size() != 0) exp_v = exp_q.pop_front();
        else exp_v = '1;
    endtask

    task automatic test_reset;
        do_reset();
        total++;
        if ({take_int, int_vec, pc_ret, in_service, cur_id, pending} !== '0) begin
            bad++;
            $display("FAIL reset_outputs: got %h want 0",
                     {take_int, int_vec, pc_ret, in_service, cur_id, pending});
        end
        n0 = n_disp;
        irq = 4'b0001;
        step(); step(); step();
        total++;
        if (pending !== 4'b0001) begin
            bad++; $display("FAIL reset_mask_pending: got %b want 0001", pending);
        end
        total++;
        if (n_disp !== n0) begin
            bad++; $display("FAIL reset_mask_nodisp: got %0d want %0d", n_disp - n0, 0);
        end
        irq = '0;
    endtask

    task automatic test_basic;
        do_reset();
        set_mask(4'b1111);
        irq = 4'b0100; exp_q.push_back(10'h3C8);
        step();
        total++;
        if ({take_int, pending} !== {1'b0, 4'b0100}) begin
            bad++; $display("FAIL basic_pending: got %b/%b want 0/0100", take_int, pending);
        end
        step();
        pop_exp();
        total++;
        if ({take_int, int_vec} !== {1'b1, exp_v}) begin
            bad++; $display("FAIL basic_dispatch: got %b/%h want 1/%h", take_int, int_vec, exp_v);
        end
        total++;
        if (cur_id !== 2'd2) begin
            bad++; $display("FAIL basic_cur_id: got %0d want 2", cur_id);
        end
        pc_next = 10'h015;
        step();
        pc_next = 10'h016;
        total++;
        if ({take_int, in_service, pc_ret} !== {1'b0, 1'b1, 10'h015}) begin
            bad++; $display("FAIL basic_service: got %b/%b/%h want 0/1/015", take_int, in_service, pc_ret);
        end
        do_reti();
        total++;
        if (in_service !== 1'b0) begin
            bad++; $display("FAIL basic_reti: got in_service %b want 0", in_service);
        end
        irq = '0;
    endtask

    task automatic test_priority;
        do_reset();
        set_mask(4'b1111);
        irq = 4'b1010; exp_q.push_back(10'h3C4); exp_q.push_back(10'h3CC);
        step(); step();
        pop_exp();
        total++;
        if ({take_int, int_vec, pending} !== {1'b1, exp_v, 4'b1000}) begin
            bad++; $display("FAIL prio_first: got %b/%h/%b want 1/%h/1000", take_int, int_vec, pending, exp_v);
        end
        pc_next = 10'h020;
        step();
        total++;
        if (pc_ret !== 10'h020) begin
            bad++; $display("FAIL prio_pc_ret: got %h want 020", pc_ret);
        end
        do_reti();
        total++;
        if ({take_int, in_service} !== 2'b00) begin
            bad++; $display("FAIL prio_idle_gap: got %b/%b want 0/0", take_int, in_service);
        end
        step();
        pop_exp();
        total++;
        if ({take_int, int_vec, cur_id} !== {1'b1, exp_v, 2'd3}) begin
            bad++; $display("FAIL prio_second: got %b/%h/%0d want 1/%h/3", take_int, int_vec, cur_id, exp_v);
        end
        step();
        do_reti();
        irq = '0;
    endtask

    task automatic test_masking;
        do_reset();
        set_mask(4'b1110);
        n0 = n_disp;
        irq = 4'b0001;
        step(); step(); step(); step();
        total++;
        if ({pending, n_disp} !== {4'b0001, n0}) begin
            bad++; $display("FAIL mask_hold: got %b/%0d want 0001/%0d", pending, n_disp, n0);
        end
        exp_q.push_back(10'h3C0);
        set_mask(4'b1111);
        total++;
        if (take_int !== 1'b0) begin
            bad++; $display("FAIL mask_early: got take_int %b want 0", take_int);
        end
        step();
        pop_exp();
        total++;
        if ({take_int, int_vec} !== {1'b1, exp_v}) begin
            bad++; $display("FAIL mask_dispatch: got %b/%h want 1/%h", take_int, int_vec, exp_v);
        end
        step();
        do_reti();
        irq = '0;
    endtask

    task automatic test_level_hold;
        do_reset();
        set_mask(4'b1111);
        n0 = n_disp;
        irq = 4'b0010; exp_q.push_back(10'h3C4);
        step(); step();
        pop_exp();
        total++;
        if ({take_int, int_vec} !== {1'b1, exp_v}) begin
            bad++; $display("FAIL level_dispatch: got %b/%h want 1/%h", take_int, int_vec, exp_v);
        end
        step();
        do_reti();
        for (int i = 0; i < 16; i++) step();
        total++;
        if (n_disp - n0 !== 1) begin
            bad++; $display("FAIL level_count: got %0d want 1", n_disp - n0);
        end
        irq = '0;
    endtask

    task automatic test_nesting;
        do_reset();
        set_mask(4'b1111);
        irq = 4'b1000; exp_q.push_back(10'h3CC);
        step(); step();
        pop_exp();
        total++;
        if ({take_int, int_vec, cur_id} !== {1'b1, exp_v, 2'd3}) begin
            bad++; $display("FAIL nest_first: got %b/%h/%0d want 1/%h/3", take_int, int_vec, cur_id, exp_v);
        end
        pc_next = 10'h100;
        step();
        irq = 4'b1001; exp_q.push_back(10'h3C0);
`ifdef INT_NEST_EN
        step(); step();
        pop_exp();
        total++;
        if ({take_int, int_vec, cur_id} !== {1'b1, exp_v, 2'd0}) begin
            bad++; $display("FAIL nest_preempt: got %b/%h/%0d want 1/%h/0", take_int, int_vec, cur_id, exp_v);
        end
        pc_next = 10'h123;
        step();
        total++;
        if (pc_ret !== 10'h123) begin
            bad++; $display("FAIL nest_pc_ret_inner: got %h want 123", pc_ret);
        end
        do_reti();
        total++;
        if ({in_service, cur_id, pc_ret} !== {1'b1, 2'd3, 10'h100}) begin
            bad++; $display("FAIL nest_resume: got %b/%0d/%h want 1/3/100", in_service, cur_id, pc_ret);
        end
        do_reti();
        total++;
        if (in_service !== 1'b0) begin
            bad++; $display("FAIL nest_exit: got in_service %b want 0", in_service);
        end
`else
        n0 = n_disp;
        step(); step(); step(); step(); step();
        total++;
        if ({n_disp, pending, cur_id, pc_ret} !== {n0, 4'b0001, 2'd3, 10'h100}) begin
            bad++; $display("FAIL nest_wait: got %0d/%b/%0d/%h want %0d/0001/3/100",
                            n_disp, pending, cur_id, pc_ret, n0);
        end
        do_reti();
        total++;
        if ({take_int, in_service} !== 2'b00) begin
            bad++; $display("FAIL nest_idle_gap: got %b/%b want 0/0", take_int, in_service);
        end
        step();
        pop_exp();
        total++;
        if ({take_int, int_vec, cur_id} !== {1'b1, exp_v, 2'd0}) begin
            bad++; $display("FAIL nest_late: got %b/%h/%0d want 1/%h/0", take_int, int_vec, cur_id, exp_v);
        end
        step();
        do_reti();
`endif
        irq = '0;
    endtask

    task automatic test_reset_mid;
        do_reset();
        set_mask(4'b1111);
        irq = 4'b0001; exp_q.push_back(10'h3C0);
        step(); step();
        pop_exp();
        total++;
        if ({take_int, int_vec} !== {1'b1, exp_v}) begin
            bad++; $display("FAIL rstmid_dispatch: got %b/%h want 1/%h", take_int, int_vec, exp_v);
        end
        pc_next = 10'h0AA;
        step();
        irq = 4'b0101;
        step();
        total++;
        if ({in_service, pending} !== {1'b1, 4'b0100}) begin
            bad++; $display("FAIL rstmid_pre: got %b/%b want 1/0100", in_service, pending);
        end
        n0 = n_disp;
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({take_int, int_vec, pc_ret, in_service, cur_id, pending} !== '0) begin
            bad++; $display("FAIL rstmid_outputs: got %h want 0",
                            {take_int, int_vec, pc_ret, in_service, cur_id, pending});
        end
        for (int i = 0; i < 10; i++) step();
        total++;
        if ({n_disp, pending} !== {n0, 4'b0101}) begin
            bad++; $display("FAIL rstmid_after: got %0d/%b want %0d/0101", n_disp, pending, n0);
        end
        irq = '0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_priority();
        test_masking();
        test_level_hold();
        test_nesting();
        test_reset_mid();
        total++;
        if (exp_q.size() !== 0) begin
            bad++; $display("FAIL scoreboard_drain: got %0d left want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
